matrix_frame_sched: RTL and testbench
=====================================

MATRIX_FRAME_SCHED -- requirements
Module: matrix_frame_sched

Interface
REQ-001 Parameter SCAN_DIV, default 8192: clock cycles per row slot, minimum 4.
REQ-002 Parameter BLANK_CYC, default 16: blanked cycles at the start of each row slot, less than SCAN_DIV.
REQ-003 Parameter DEB_CYC, default 65536: stable cycles required to accept a key level change.
REQ-004 Parameter FRAME_HOLD, default 32: complete 8-row scans per frame while in animate mode.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port key_in, input, 2 bits: raw push keys, active-high, asynchronous to clk; bit0 = NEXT, bit1 = MODE.
REQ-008 Port en, output, 8 bits, registered: row enable, active-low one-hot; bit r low selects row r.
REQ-009 Port dataout, output, 8 bits, registered: column data for the enabled row, active-high.
REQ-010 Port frame_idx, output, 2 bits, registered: index of the frame currently displayed.
REQ-011 Port anim, output, 1 bit, registered: 1 = animate mode, 0 = static mode.

Function
REQ-012 Row slot counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, row index SHALL advance 0..7 and wrap 7->0.
REQ-013 While slot count < BLANK_CYC: en SHALL be 8'hFF and dataout SHALL be 8'h00.
REQ-014 From slot count BLANK_CYC to SCAN_DIV-1: en SHALL be ~(1<<row) and dataout SHALL be ROM[frame_idx][row].
REQ-015 en and dataout SHALL update on the same edge; no cycle SHALL have two rows enabled.
REQ-016 ROM frame 0, rows 0..7 (hex): 00 66 66 00 81 81 42 3C.
REQ-017 ROM frame 1, rows 0..7 (hex): 00 66 66 00 3C 42 81 81.
REQ-018 ROM frame 2, rows 0..7 (hex): 18 3C 7E FF FF 7E 3C 18.
REQ-019 ROM frame 3, rows 0..7 (hex): AA 55 AA 55 AA 55 AA 55.
REQ-020 Each key_in bit SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-021 Debouncer: the debounced level SHALL change only after the synchronized level differs from it for DEB_CYC consecutive cycles; any mismatch gap SHALL restart the count.
REQ-022 A press SHALL be a debounced 0->1 transition; each press SHALL be a single-cycle event; releases SHALL be ignored.
REQ-023 FSM has two states: STATIC (anim=0) and ANIM (anim=1).
REQ-024 MODE press SHALL toggle STATIC<->ANIM and clear the hold counter.
REQ-025 NEXT press in STATIC SHALL set the pending frame to (pending+1) mod 4.
REQ-026 NEXT press in ANIM SHALL be ignored.
REQ-027 In ANIM, the hold counter SHALL count completed scans (row 7 slot wrap); on reaching FRAME_HOLD, it SHALL clear and the pending frame SHALL increment mod 4.
REQ-028 MODE and NEXT presses in the same cycle: MODE SHALL take effect and NEXT SHALL be discarded.
REQ-029 frame_idx SHALL load the pending frame only on the edge where row 7 wraps to row 0 (tear-free); otherwise it SHALL hold.
REQ-030 Multiple NEXT presses within one scan SHALL accumulate in the pending frame; only the final value is displayed.

Reset
REQ-031 While rst=1: slot count=0, row=0, en=8'hFF, dataout=8'h00, frame_idx=0, pending=0, anim=0, hold=0, synchronizers and debounced levels=0, debounce counters=0.
REQ-032 Reset assertion SHALL take effect asynchronously, mid-slot or mid-debounce, with no press generated on release.
REQ-033 After rst falls, the first row 0 slot SHALL begin at count 0, blanked for BLANK_CYC cycles.

Verification (SCAN_DIV=8, BLANK_CYC=2, DEB_CYC=4, FRAME_HOLD=2)
REQ-034 Release reset, no keys -> en cycles FF,FF then FE for 6 cycles; row 4 shows dataout 81; sequence repeats every 64 cycles; frame_idx=0.
REQ-035 NEXT high for 3 cycles, then low -> no press; pending and frame_idx stay 0.
REQ-036 NEXT high for 10 cycles mid-row-3 -> frame_idx becomes 1 exactly at the next row 7->0 wrap; row 4 then shows 3C.
REQ-037 MODE press -> anim=1; frame_idx advances 0->1->2->3->0, one step every 128 cycles, each at a row-0 boundary; NEXT presses are ignored.
REQ-038 MODE and NEXT debounced presses in the same cycle -> anim toggles; frame unchanged.
REQ-039 rst pulse mid-row-5 in ANIM with frame 2 -> en=FF, dataout=00, frame_idx=0, anim=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/matrix_frame_sched.sv
// ---------------------------------------------------------------------------
// matrix_frame_sched
//
// Drives an 8x8 LED matrix, one row at a time, from a four-frame pattern ROM.
// Each row occupies a slot of SCAN_DIV clock cycles. The first BLANK_CYC
// cycles of every slot are blanked so the row drivers can settle without
// ghosting. Two push keys select what is shown:
//   NEXT (key_in[0]) - in static mode, step to the next frame
//   MODE (key_in[1]) - toggle between static and animate mode
// In animate mode the frame advances on its own every FRAME_HOLD full scans.
// A new frame is only adopted at the row 7 -> row 0 boundary, so a scan
// never mixes rows from two different frames.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   key_in    in   2  raw keys, active-high, asynchronous (bit0 NEXT, bit1 MODE)
//   en        out  8  row enables, active-low one-hot (all high while blanked)
//   dataout   out  8  column data for the enabled row, active-high
//   frame_idx out  2  frame currently displayed
//   anim      out  1  1 = animate mode, 0 = static mode
// ---------------------------------------------------------------------------
module matrix_frame_sched #(
   parameter int SCAN_DIV   = 8192,
   parameter int BLANK_CYC  = 16,
   parameter int DEB_CYC    = 65536,
   parameter int FRAME_HOLD = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] key_in,
   output logic [7:0] en,
   output logic [7:0] dataout,
   output logic [1:0] frame_idx,
   output logic       anim
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEB_CYC + 1);
   localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD + 1) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(FRAME_HOLD - 1);

   typedef enum logic [0:0] {
      ST_STATIC = 1'b0,
      ST_ANIM   = 1'b1
   } state_t;

   // Pattern ROM. Each frame is packed with row 0 in the least significant
   // byte so the row index selects an 8-bit lane directly.
   function automatic logic [7:0] rom_row(input logic [1:0] frame, input logic [2:0] row);
      logic [63:0] bits;
      case (frame)
         2'd0:    bits = 64'h3C42_8181_0066_6600;
         2'd1:    bits = 64'h8181_423C_0066_6600;
         2'd2:    bits = 64'h183C_7EFF_FF7E_3C18;
         2'd3:    bits = 64'h55AA_55AA_55AA_55AA;
         default: bits = 64'h0000_0000_0000_0000;
      endcase
      return bits[{row, 3'b000} +: 8];
   endfunction

   // ---------------------------------------------------------------------
   // Key conditioning: 2-flop synchronizer and debouncer per key
   // ---------------------------------------------------------------------
   logic [1:0]    sync1_r;
   logic [1:0]    sync2_r;
   logic [1:0]    deb_r;
   logic [DW-1:0] dcnt_r [2];
   logic [1:0]    press_s;

   // Synchronize the raw keys and debounce the synchronized level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
         deb_r   <= 2'b00;
         for (int b = 0; b < 2; b++) begin
            dcnt_r[b] <= '0;
         end
      end else begin
         sync1_r <= key_in;
         sync2_r <= sync1_r;
         for (int b = 0; b < 2; b++) begin
            if (sync2_r[b] != deb_r[b]) begin
               // Accept the new level only after DEB_CYC consecutive
               // disagreeing cycles; any agreeing cycle restarts the run.
               if (dcnt_r[b] == DEB_LAST) begin
                  deb_r[b]  <= sync2_r[b];
                  dcnt_r[b] <= '0;
               end else begin
                  dcnt_r[b] <= dcnt_r[b] + DW'(1);
               end
            end else begin
               dcnt_r[b] <= '0;
            end
         end
      end
   end

   // A press is the single cycle in which the debounced level is about to
   // rise; acting on it in that same edge avoids a separate edge detector.
   always_comb begin
      press_s = 2'b00;
      for (int b = 0; b < 2; b++) begin
         if ((sync2_r[b] == 1'b1) && (deb_r[b] == 1'b0) && (dcnt_r[b] == DEB_LAST)) begin
            press_s[b] = 1'b1;
         end else begin
            press_s[b] = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Row scan timing
   // ---------------------------------------------------------------------
   logic [CW-1:0] cnt_r;
   logic [2:0]    row_r;
   logic [CW-1:0] cnt_nxt_s;
   logic [2:0]    row_nxt_s;
   logic          scan_done_s;

   // Next slot position; the row advances when the slot counter wraps.
   always_comb begin
      cnt_nxt_s   = cnt_r;
      row_nxt_s   = row_r;
      scan_done_s = 1'b0;
      if (cnt_r == CNT_LAST) begin
         cnt_nxt_s = '0;
         row_nxt_s = row_r + 3'd1;
         if (row_r == 3'd7) begin
            scan_done_s = 1'b1;
         end else begin
            scan_done_s = 1'b0;
         end
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
   end

   // Slot counter and row index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
         row_r <= 3'd0;
      end else begin
         cnt_r <= cnt_nxt_s;
         row_r <= row_nxt_s;
      end
   end

   // ---------------------------------------------------------------------
   // Mode FSM, pending frame and hold counter
   // ---------------------------------------------------------------------
   state_t        state_r;
   state_t        state_nxt_s;
   logic [HW-1:0] hold_r;
   logic [HW-1:0] hold_nxt_s;
   logic [1:0]    pend_r;
   logic [1:0]    pend_nxt_s;
   logic [1:0]    frame_r;
   logic [1:0]    frame_nxt_s;

   // Next-state logic. MODE has priority, so a NEXT press arriving in the
   // same cycle is dropped.
   always_comb begin
      state_nxt_s = state_r;
      hold_nxt_s  = hold_r;
      pend_nxt_s  = pend_r;
      case (state_r)
         ST_STATIC: begin
            if (press_s[1]) begin
               state_nxt_s = ST_ANIM;
               hold_nxt_s  = '0;
            end else if (press_s[0]) begin
               pend_nxt_s = pend_r + 2'd1;
            end else begin
               pend_nxt_s = pend_r;
            end
         end
         ST_ANIM: begin
            if (press_s[1]) begin
               state_nxt_s = ST_STATIC;
               hold_nxt_s  = '0;
            end else if (scan_done_s) begin
               if (hold_r == HOLD_LAST) begin
                  hold_nxt_s = '0;
                  pend_nxt_s = pend_r + 2'd1;
               end else begin
                  hold_nxt_s = hold_r + HW'(1);
               end
            end else begin
               hold_nxt_s = hold_r;
            end
         end
         default: begin
            state_nxt_s = ST_STATIC;
            hold_nxt_s  = '0;
         end
      endcase
   end

   // The displayed frame only changes at the end of a complete scan and
   // takes the pending value as updated on that same edge.
   always_comb begin
      if (scan_done_s) begin
         frame_nxt_s = pend_nxt_s;
      end else begin
         frame_nxt_s = frame_r;
      end
   end

   // Mode state, hold counter, pending and displayed frame registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_STATIC;
         hold_r  <= '0;
         pend_r  <= 2'd0;
         frame_r <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         hold_r  <= hold_nxt_s;
         pend_r  <= pend_nxt_s;
         frame_r <= frame_nxt_s;
      end
   end

   // ---------------------------------------------------------------------
   // Registered matrix outputs
   // ---------------------------------------------------------------------
   logic [7:0] en_r;
   logic [7:0] data_r;
   logic       anim_r;

   // Outputs are computed from the next slot position and next frame so
   // that en and dataout line up with the slot counter they describe and
   // change together on one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_r   <= 8'hFF;
         data_r <= 8'h00;
         anim_r <= 1'b0;
      end else begin
         if (cnt_nxt_s < BLANK_END) begin
            en_r   <= 8'hFF;
            data_r <= 8'h00;
         end else begin
            en_r   <= ~(8'd1 << row_nxt_s);
            data_r <= rom_row(frame_nxt_s, row_nxt_s);
         end
         anim_r <= (state_nxt_s == ST_ANIM);
      end
   end

   assign en        = en_r;
   assign dataout   = data_r;
   assign frame_idx = frame_r;
   assign anim      = anim_r;

endmodule

// File: tb/tb_matrix_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_matrix_frame_sched
//
// Self-checking bench for matrix_frame_sched with small parameters. A
// behavioural model tracks time since reset, derives the slot position and
// row with plain arithmetic, applies the key/debounce and frame rules, and
// predicts every output each cycle. Stimulus is a short directed prologue
// followed by random key segments with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_matrix_frame_sched;

   localparam int SCAN_DIV   = 8;
   localparam int BLANK_CYC  = 2;
   localparam int DEB_CYC    = 4;
   localparam int FRAME_HOLD = 2;
   localparam int SCAN_LEN   = SCAN_DIV * 8;

   logic       clk;
   logic       rst;
   logic [1:0] key_in;
   logic [7:0] en;
   logic [7:0] dataout;
   logic [1:0] frame_idx;
   logic       anim;

   matrix_frame_sched #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC),
      .DEB_CYC   (DEB_CYC),
      .FRAME_HOLD(FRAME_HOLD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in),
      .en       (en),
      .dataout  (dataout),
      .frame_idx(frame_idx),
      .anim     (anim)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] rom_tbl [0:3][0:7] = '{
      '{8'h00, 8'h66, 8'h66, 8'h00, 8'h81, 8'h81, 8'h42, 8'h3C},
      '{8'h00, 8'h66, 8'h66, 8'h00, 8'h3C, 8'h42, 8'h81, 8'h81},
      '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18},
      '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55}
   };

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int cyc_cnt  = 0;

   // Reference model state
   int m_t;
   int m_s1 [2];
   int m_s2 [2];
   int m_deb [2];
   int m_run [2];
   int m_anim;
   int m_hold;
   int m_pend;
   int m_frame;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      vec_cnt++;
      if (obs !== exp_v) begin
         miss_cnt++;
         $display("FAIL %s: got %02h expected %02h (cycle %0d, t=%0d)", tag, obs, exp_v, cyc_cnt, m_t);
      end
   endtask

   task automatic model_reset();
      m_t = 0;
      for (int b = 0; b < 2; b++) begin
         m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_run[b] = 0;
      end
      m_anim = 0; m_hold = 0; m_pend = 0; m_frame = 0;
   endtask

   // One rising clock edge of the reference model, with key value k sampled.
   task automatic model_edge(input logic [1:0] k);
      int  p [2];
      bit  done;
      for (int b = 0; b < 2; b++) begin
         p[b] = 0;
         if (m_s2[b] != m_deb[b]) begin
            m_run[b]++;
            if (m_run[b] == DEB_CYC) begin
               m_deb[b] = m_s2[b];
               m_run[b] = 0;
               p[b] = m_deb[b];
            end
         end else begin
            m_run[b] = 0;
         end
      end
      for (int b = 0; b < 2; b++) begin
         m_s2[b] = m_s1[b];
         m_s1[b] = int'(k[b]);
      end
      m_t++;
      done = ((m_t % SCAN_LEN) == 0);
      if (p[1] != 0) begin
         m_anim = 1 - m_anim;
         m_hold = 0;
      end else if (p[0] != 0 && m_anim == 0) begin
         m_pend = (m_pend + 1) % 4;
      end else if (m_anim != 0 && done) begin
         m_hold++;
         if (m_hold == FRAME_HOLD) begin
            m_hold = 0;
            m_pend = (m_pend + 1) % 4;
         end
      end
      if (done) m_frame = m_pend;
   endtask

   task automatic compare_all();
      int         pos;
      int         row;
      logic [7:0] exp_en;
      logic [7:0] exp_d;
      logic [7:0] one;
      pos = m_t % SCAN_DIV;
      row = (m_t / SCAN_DIV) % 8;
      one = 8'd1;
      if (pos < BLANK_CYC) begin
         exp_en = 8'hFF;
         exp_d  = 8'h00;
      end else begin
         exp_en = ~(one << row);
         exp_d  = rom_tbl[m_frame][row];
      end
      chk("en", en, exp_en);
      chk("dataout", dataout, exp_d);
      chk("frame_idx", {6'd0, frame_idx}, 8'(m_frame));
      chk("anim", {7'd0, anim}, 8'(m_anim));
   endtask

   // Called at a falling edge: drive k, let one rising edge occur, check.
   task automatic step(input logic [1:0] k);
      key_in = k;
      @(posedge clk);
      model_edge(k);
      @(negedge clk);
      cyc_cnt++;
      compare_all();
   endtask

   task automatic hold_keys(input logic [1:0] k, input int n);
      for (int i = 0; i < n; i++) step(k);
   endtask

   // Asynchronous reset pulse placed between clock edges; outputs must
   // clear before the next rising edge.
   task automatic async_reset_pulse();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_en", en, 8'hFF);
      chk("rst_dataout", dataout, 8'h00);
      chk("rst_frame", {6'd0, frame_idx}, 8'h00);
      chk("rst_anim", {7'd0, anim}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare_all();
   endtask

   initial begin
      int seg_k;
      int seg_len;
      rst    = 1'b1;
      key_in = 2'b00;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;

      // Idle scan, then short NEXT glitch that must not register.
      hold_keys(2'b00, 70);
      hold_keys(2'b01, 3);
      hold_keys(2'b00, 80);
      // Accepted NEXT press in static mode.
      hold_keys(2'b01, 10);
      hold_keys(2'b00, 120);
      // Enter animate mode and let it advance; NEXT presses ignored.
      hold_keys(2'b10, 8);
      hold_keys(2'b00, 100);
      hold_keys(2'b01, 8);
      hold_keys(2'b00, 300);
      // Reset while animating.
      async_reset_pulse();
      // MODE and NEXT together.
      hold_keys(2'b11, 8);
      hold_keys(2'b00, 40);
      hold_keys(2'b11, 8);
      hold_keys(2'b00, 40);

      // Random segments.
      while (cyc_cnt < 5000) begin
         if ($urandom_range(0, 39) == 0) begin
            async_reset_pulse();
         end else begin
            seg_k = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) seg_len = int'($urandom_range(20, 150));
            else seg_len = int'($urandom_range(1, 8));
            hold_keys(2'(seg_k), seg_len);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
